// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

   // Controller states; encoding is visible on the fsm_state debug output.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_HOLD = 2'd2
   } fir_state_e;

   // Width of the intermediate value handed to the saturation helper.
   localparam int SAT_W = 64;

   // Accumulator width that can hold the sum of NUM_TAPS full-precision products.
   function automatic int calc_acc_w(input int data_w, input int coeff_w, input int num_taps);
      return data_w + coeff_w + $clog2(num_taps);
   endfunction

   // Clamp a signed value into the range of a signed out_w-bit number.
   function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] val,
                                                        input int out_w);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (val > hi) begin
         return hi;
      end else if (val < lo) begin
         return lo;
      end else begin
         return val;
      end
   endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient register file: writable only while the controller is idle,
// read combinationally by the current tap index.
module fir_coeff_bank
   import fir_pkg::*;
#(
   parameter int NUM_TAPS = 4,
   parameter int COEFF_W  = 8,
   parameter int ADDR_W   = $clog2(NUM_TAPS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  fir_state_e                state,
   input  logic                      we,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic signed [COEFF_W-1:0] wr_data,
   input  logic [ADDR_W-1:0]         rd_idx,
   output logic signed [COEFF_W-1:0] rd_data
);

   logic signed [COEFF_W-1:0] coeff [NUM_TAPS];
   logic                      wr_en;

   // Writes outside IDLE or beyond the last tap are dropped so a running
   // computation always sees a frozen coefficient set.
   assign wr_en = we && (state == ST_IDLE) &&
                  ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_TAPS));

   // Coefficient storage, cleared on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            coeff[k] <= '0;
         end
      end else if (wr_en) begin
         coeff[wr_addr] <= wr_data;
      end
   end

   assign rd_data = coeff[rd_idx];

endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR filter: one shared multiply-accumulate walks the taps,
// then the scaled and saturated result is held until downstream takes it.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_ready is high only in IDLE without clear; out_valid, once high,
// keeps out_data stable until the edge where out_ready is seen high.
module fir_seq_mac
   import fir_pkg::*;
#(
   parameter int NUM_TAPS  = 4,
   parameter int DATA_W    = 8,
   parameter int COEFF_W   = 8,
   parameter int OUT_W     = 8,
   parameter int OUT_SHIFT = 0,
   parameter int ACC_W     = calc_acc_w(DATA_W, COEFF_W, NUM_TAPS)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic signed [DATA_W-1:0]            in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic signed [OUT_W-1:0]             out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   input  logic                                coeff_we,
   input  logic [$clog2(NUM_TAPS)-1:0]         coeff_addr,
   input  logic signed [COEFF_W-1:0]           coeff_data,
   input  logic                                clear,
   output logic                                busy,
   output logic [1:0]                          fsm_state
);

   localparam int ADDR_W = $clog2(NUM_TAPS);
   localparam int PROD_W = DATA_W + COEFF_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);

   fir_state_e                state;
   logic [ADDR_W-1:0]         idx;
   logic signed [ACC_W-1:0]   acc;
   logic signed [DATA_W-1:0]  x [NUM_TAPS];

   logic signed [DATA_W-1:0]  x_sel;
   logic signed [COEFF_W-1:0] c_sel;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   acc_shift;
   logic signed [SAT_W-1:0]   acc_wide;
   logic signed [SAT_W-1:0]   sat_val;

   logic                      accept;
   logic                      clear_idle;

   // clear wins over a sample in the same IDLE cycle, so it masks in_ready.
   assign in_ready   = (state == ST_IDLE) && !clear;
   assign accept     = in_valid && in_ready;
   assign clear_idle = (state == ST_IDLE) && clear;
   assign busy       = (state != ST_IDLE);
   assign fsm_state  = state;

   fir_coeff_bank #(
      .NUM_TAPS (NUM_TAPS),
      .COEFF_W  (COEFF_W),
      .ADDR_W   (ADDR_W)
   ) u_coeff_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .state   (state),
      .we      (coeff_we),
      .wr_addr (coeff_addr),
      .wr_data (coeff_data),
      .rd_idx  (idx),
      .rd_data (c_sel)
   );

   // Datapath: current tap product, running sum, and scaled/saturated result.
   always_comb begin
      x_sel     = x[idx];
      prod      = PROD_W'(x_sel) * PROD_W'(c_sel);
      acc_sum   = acc + ACC_W'(prod);
      acc_shift = acc_sum >>> OUT_SHIFT;
      acc_wide  = SAT_W'(acc_shift);
      sat_val   = saturate(acc_wide, OUT_W);
   end

   // Delay line: shifts in a new sample on accept, zeroed by clear in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            x[k] <= '0;
         end
      end else if (clear_idle) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            x[k] <= '0;
         end
      end else if (accept) begin
         x[0] <= in_data;
         for (int k = 1; k < NUM_TAPS; k++) begin
            x[k] <= x[k-1];
         end
      end
   end

   // Controller: accept, one tap per cycle, then hold the result for downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  acc   <= '0;
                  idx   <= '0;
                  state <= ST_MAC;
               end
            end
            ST_MAC: begin
               acc <= acc_sum;
               if (idx == LAST_IDX) begin
                  out_data  <= OUT_W'(sat_val);
                  out_valid <= 1'b1;
                  idx       <= '0;
                  state     <= ST_HOLD;
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
